fifo_flags: RTL and testbench

Parametrised synchronous FIFO, successor to the basic byte FIFO used between the UART receiver/transmitter and the interface FSM. Adds arbitrary (non-power-of-two) depth, an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. Drop-in for the existing FIFO ports; the extra outputs may be left unconnected.

---
 rtl/fifo_flags.sv | 183 ++++++++++++++++++
 tb/tb_fifo_flags.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flags.sv
// ---------------------------------------------------------------------------
// fifo_flags
//
// Parametrised single-clock FIFO with arbitrary (non power-of-two) depth,
// occupancy count, programmable almost-full / almost-empty thresholds,
// sticky overflow / underflow flags, synchronous flush and an optional
// first-word-fall-through (FWFT) read mode.
//
// Ports:
//   i_clock        clock, all state changes on the rising edge
//   i_reset        synchronous active-high reset (clears contents and flags)
//   i_flush        synchronous flush (clears contents, keeps error flags)
//   i_write/i_data write request and write data
//   i_read         read request (pop / acknowledge in FWFT mode)
//   o_data         read data (registered, or head-of-queue in FWFT mode)
//   o_empty        count == 0
//   o_full         count == LENGTH
//   o_almost_empty count <= AEMPTY_LEVEL
//   o_almost_full  count >= AFULL_LEVEL
//   o_count        current occupancy 0..LENGTH
//   o_overflow     sticky: write attempted while full and not accepted
//   o_underflow    sticky: read attempted while empty
// ---------------------------------------------------------------------------
module fifo_flags #(
  parameter int DATA_WIDTH   = 8,
  parameter int LENGTH       = 4,
  parameter int AFULL_LEVEL  = LENGTH - 1,
  parameter int AEMPTY_LEVEL = 1,
  parameter int FWFT         = 0
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_flush,
  input  logic                          i_write,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          i_read,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic                          o_empty,
  output logic                          o_full,
  output logic                          o_almost_empty,
  output logic                          o_almost_full,
  output logic [$clog2(LENGTH+1)-1:0]   o_count,
  output logic                          o_overflow,
  output logic                          o_underflow
);

  localparam int PTR_W = $clog2(LENGTH);
  localparam int CNT_W = $clog2(LENGTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(LENGTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(LENGTH);
  localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_LEVEL);
  localparam logic [CNT_W-1:0] CNT_AEMPT = CNT_W'(AEMPTY_LEVEL);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

  // Pointers wrap explicitly at LENGTH-1 so non power-of-two depths never
  // index past the last storage entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = ptr + PTR_W'(1'b1);
    end
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [LENGTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;
  logic [DATA_WIDTH-1:0] data_q,   data_d;
  logic                  ovf_q,    ovf_d;
  logic                  udf_q,    udf_d;

  logic empty_s;
  logic full_s;
  logic rd_ok_s;
  logic wr_ok_s;

  assign empty_s = (count_q == '0);
  assign full_s  = (count_q == CNT_FULL);

  // Next-state logic: flush overrides read/write; reset is applied in the
  // register block and therefore overrides everything here.
  always_comb begin
    rd_ok_s  = 1'b0;
    wr_ok_s  = 1'b0;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ok_s = i_read && !empty_s;
      // A read in the same cycle frees a slot, so a full FIFO still accepts.
      wr_ok_s = i_write && (!full_s || rd_ok_s);

      if (rd_ok_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      if (wr_ok_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase

      if (i_write && !wr_ok_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end

      if (i_read && empty_s) begin
        udf_d = 1'b1;
      end else begin
        udf_d = udf_q;
      end

      if (rd_ok_s && (FWFT == 0)) begin
        data_d = mem_q[rd_ptr_q];
      end else begin
        data_d = data_q;
      end
    end
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array; not cleared by reset or flush, only the pointers are.
  always_ff @(posedge i_clock) begin
    if (wr_ok_s && !i_reset) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  // Read data path: registered in standard mode, head-of-queue in FWFT mode.
  generate
    if (FWFT != 0) begin : g_fwft
      assign o_data = empty_s ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
      assign o_data = data_q;
    end
  endgenerate

  assign o_empty        = empty_s;
  assign o_full         = full_s;
  assign o_almost_empty = (count_q <= CNT_AEMPT);
  assign o_almost_full  = (count_q >= CNT_AFULL);
  assign o_count        = count_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = udf_q;

endmodule

// File: tb/tb_fifo_flags.sv
// ---------------------------------------------------------------------------
// tb_fifo_flags
//
// Three FIFO instances share one stimulus stream: LENGTH=4 standard mode,
// LENGTH=5 standard mode with non-default thresholds, LENGTH=4 FWFT mode.
// Each instance is compared every cycle against a queue-based model; a
// directed table and hand-written sequences add explicit expectations.
// ---------------------------------------------------------------------------
module tb_fifo_flags;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       fl;
  logic       wr;
  logic       rd;
  logic [7:0] din;

  logic [7:0] dout [3];
  logic [2:0] cnt  [3];
  logic       emp  [3];
  logic       ful  [3];
  logic       aemp [3];
  logic       aful [3];
  logic       ovf  [3];
  logic       udf  [3];

  int checks   = 0;
  int failures = 0;

  // Model configuration mirrors the instance parameters.
  int len_m [3] = '{4, 5, 4};
  int af_m  [3] = '{3, 4, 3};
  int ae_m  [3] = '{1, 2, 1};
  int fw_m  [3] = '{0, 0, 1};

  logic [7:0] mq [3][$];
  int         mdat [3];
  int         movf [3];
  int         mudf [3];

  fifo_flags #(.DATA_WIDTH(8), .LENGTH(4), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1), .FWFT(0)) u_std4 (
    .i_clock(clk), .i_reset(rst), .i_flush(fl), .i_write(wr), .i_data(din), .i_read(rd),
    .o_data(dout[0]), .o_empty(emp[0]), .o_full(ful[0]), .o_almost_empty(aemp[0]),
    .o_almost_full(aful[0]), .o_count(cnt[0]), .o_overflow(ovf[0]), .o_underflow(udf[0])
  );

  fifo_flags #(.DATA_WIDTH(8), .LENGTH(5), .AFULL_LEVEL(4), .AEMPTY_LEVEL(2), .FWFT(0)) u_std5 (
    .i_clock(clk), .i_reset(rst), .i_flush(fl), .i_write(wr), .i_data(din), .i_read(rd),
    .o_data(dout[1]), .o_empty(emp[1]), .o_full(ful[1]), .o_almost_empty(aemp[1]),
    .o_almost_full(aful[1]), .o_count(cnt[1]), .o_overflow(ovf[1]), .o_underflow(udf[1])
  );

  fifo_flags #(.DATA_WIDTH(8), .LENGTH(4), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1), .FWFT(1)) u_fwft4 (
    .i_clock(clk), .i_reset(rst), .i_flush(fl), .i_write(wr), .i_data(din), .i_read(rd),
    .o_data(dout[2]), .o_empty(emp[2]), .o_full(ful[2]), .o_almost_empty(aemp[2]),
    .o_almost_full(aful[2]), .o_count(cnt[2]), .o_overflow(ovf[2]), .o_underflow(udf[2])
  );

  typedef struct {
    logic       r;
    logic       f;
    logic       w;
    logic       rd;
    logic [7:0] d;
    int         cnt;
    int         dat;
    int         ov;
    int         un;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Behavioural rules of one FIFO applied to one clock edge.
  task automatic model_edge(input int k, input logic r, input logic f, input logic w,
                            input logic rd_i, input logic [7:0] d);
    bit rok;
    bit wok;
    int n;
    n = mq[k].size();
    if (r) begin
      mq[k].delete();
      movf[k] = 0;
      mudf[k] = 0;
      mdat[k] = 0;
    end else if (f) begin
      mq[k].delete();
    end else begin
      rok = rd_i && (n > 0);
      wok = w && ((n < len_m[k]) || rok);
      if (w && !wok) movf[k] = 1;
      if (rd_i && (n == 0)) mudf[k] = 1;
      if (rok) mdat[k] = int'(mq[k].pop_front());
      if (wok) mq[k].push_back(d);
    end
  endtask

  task automatic check_dut(input int k);
    int n;
    n = mq[k].size();
    chk($sformatf("d%0d_count", k), int'(cnt[k]), n);
    chk($sformatf("d%0d_empty", k), int'(emp[k]), int'(n == 0));
    chk($sformatf("d%0d_full", k), int'(ful[k]), int'(n == len_m[k]));
    chk($sformatf("d%0d_aempty", k), int'(aemp[k]), int'(n <= ae_m[k]));
    chk($sformatf("d%0d_afull", k), int'(aful[k]), int'(n >= af_m[k]));
    chk($sformatf("d%0d_ovf", k), int'(ovf[k]), movf[k]);
    chk($sformatf("d%0d_udf", k), int'(udf[k]), mudf[k]);
    if (fw_m[k] == 0) begin
      chk($sformatf("d%0d_data", k), int'(dout[k]), mdat[k]);
    end else if (n > 0) begin
      chk($sformatf("d%0d_head", k), int'(dout[k]), int'(mq[k][0]));
    end
  endtask

  // Drive on the falling edge, update the models at the rising edge and
  // compare all instances 1 time unit later.
  task automatic step(input logic r, input logic f, input logic w, input logic rd_i,
                      input logic [7:0] d);
    @(negedge clk);
    rst = r;
    fl  = f;
    wr  = w;
    rd  = rd_i;
    din = d;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k, r, f, w, rd_i, d);
    #1;
    for (int k = 0; k < 3; k++) check_dut(k);
  endtask

  initial begin
    rst = 1'b1;
    fl  = 1'b0;
    wr  = 1'b0;
    rd  = 1'b0;
    din = 8'h00;
    for (int k = 0; k < 3; k++) begin
      mdat[k] = 0;
      movf[k] = 0;
      mudf[k] = 0;
    end

    //            r     f     w     rd    d      cnt dat    ov un
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h00, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 1, 8'h00, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 2, 8'h00, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 3, 8'h00, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 4, 8'h00, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 4, 8'h00, 1, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3, 8'h11, 1, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2, 8'h22, 1, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1, 8'h33, 1, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h44, 1, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h44, 1, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1, 8'h44, 1, 1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h00, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 1, 8'h00, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 2, 8'h00, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 3, 8'h00, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 4, 8'h00, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 4, 8'h11, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 4, 8'h22, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 4, 8'h33, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 4, 8'h44, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 4, 8'h66, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h66, 4, 8'h66, 0, 0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 0, 8'h66, 0, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h66, 0, 1});

    // Directed table against the LENGTH=4 standard-mode instance.
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].f, tbl[i].w, tbl[i].rd, tbl[i].d);
      chk($sformatf("tbl%0d_count", i), int'(cnt[0]), tbl[i].cnt);
      chk($sformatf("tbl%0d_data", i), int'(dout[0]), tbl[i].dat);
      chk($sformatf("tbl%0d_ovf", i), int'(ovf[0]), tbl[i].ov);
      chk($sformatf("tbl%0d_udf", i), int'(udf[0]), tbl[i].un);
    end

    // LENGTH=5 wrap: 12 writes with a read every other cycle, then drain.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 1'(i % 2), 8'(8'h20 + i));
    chk("len5_count_after_fill", int'(cnt[1]), 5);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

    // FWFT: head visible without a read, pop advances head, flush keeps flags.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("fwft_udf_set", int'(udf[2]), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h7E);
    chk("fwft_head_7e", int'(dout[2]), 8'h7E);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h02);
    chk("fwft_head_hold", int'(dout[2]), 8'h7E);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("fwft_head_pop", int'(dout[2]), 8'h01);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h03);
    chk("fwft_count3", int'(cnt[2]), 3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("fwft_flush_count", int'(cnt[2]), 0);
    chk("fwft_flush_empty", int'(emp[2]), 1);
    chk("fwft_flush_udf_kept", int'(udf[2]), 1);

    // Randomised traffic alternating write-heavy and read-heavy phases.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 600; i++) begin
      int wp;
      int rp;
      wp = (((i / 100) % 2) == 0) ? 75 : 30;
      rp = (((i / 100) % 2) == 0) ? 35 : 75;
      step(1'($urandom_range(0, 149) == 0),
           1'($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 99) < wp),
           1'($urandom_range(0, 99) < rp),
           8'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
